arb_mux_2d: RTL

ARB_MUX_2D -- requirements
Module: arb_mux_2d

---
 rtl/fifo_2d.sv | 75 +++++++
 rtl/arb_mux_2d.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fifo_2d.sv
`default_nettype none
// ============================================================================
// Module      : fifo_2d
// Description : Two-entry elastic buffer with valid/ready handshakes on both
//               sides. A full buffer still accepts a beat in a cycle where
//               its head is being drained, so a continuously fed and drained
//               buffer sustains one beat per cycle. Push and pop in the same
//               cycle keep the beats in order.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_data/i_valid   - upstream beat
//               o_ready          - buffer can take a beat this cycle
//               o_data/o_valid   - head of buffer (combinational, no latency)
//               i_ready          - downstream pops the head this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_2d #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  logic             w_push;
  logic             w_pop;

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];

  // A full buffer is always non-empty, so a pop request frees a slot for
  // the incoming beat in the same cycle.
  assign o_ready = (r_count != 2'd2) || i_ready;

  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_mux_2d.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_2d
// Description : N-way burst-aware round-robin multiplexer. Every requester
//               feeds a two-entry buffer; the buffer heads are arbitrated
//               round-robin and a burst (beats up to and including last=1)
//               holds the grant until it completes. A beat offered while
//               unlocked keeps its grant until it is accepted downstream.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               in_data    - N*WIDTH payload, requester i at [i*WIDTH +: WIDTH]
//               in_last    - per-requester end-of-burst flag
//               in_valid   - per-requester valid
//               in_ready   - per-requester ready (from its buffer)
//               out_data   - payload of the selected beat
//               out_last   - end-of-burst flag of the selected beat
//               out_id     - index of the currently granted requester
//               out_valid  - selected beat valid
//               out_ready  - downstream ready
//               locked     - burst in progress, grant held
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux_2d #(
  parameter int WIDTH = 64,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_id,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               locked
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  // Buffer heads carry {last, data}.
  logic [WIDTH:0]   w_head [N];
  logic [N-1:0]     w_nonempty;
  logic [N-1:0]     w_pop;

  // Arbitration state.
  logic [IDW-1:0]   r_rr_ptr;
  logic             r_locked;
  logic [IDW-1:0]   r_lock_id;
  logic             r_pend_valid;
  logic [IDW-1:0]   r_pend_id;

  logic             w_rr_found;
  logic [IDW-1:0]   w_rr_idx;
  logic [IDW-1:0]   w_grant;
  logic [IDW-1:0]   w_next_ptr;
  logic             w_out_valid;
  logic             w_xfer;

  // --------------------------------------------------------------------------
  // Per-requester buffers
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < N; i++) begin : g_req
      fifo_2d #(
        .WIDTH (WIDTH + 1)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_data  ({in_last[i], in_data[i*WIDTH +: WIDTH]}),
        .i_valid (in_valid[i]),
        .o_ready (in_ready[i]),
        .o_data  (w_head[i]),
        .o_valid (w_nonempty[i]),
        .i_ready (w_pop[i])
      );

      // Only the granted buffer is drained, and only on a real transfer.
      assign w_pop[i] = w_xfer && (w_grant == IDW'(i));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin search: first non-empty buffer starting at r_rr_ptr,
  // wrapping from N-1 back to 0.
  // --------------------------------------------------------------------------
  always_comb begin
    int j;
    w_rr_found = 1'b0;
    w_rr_idx   = r_rr_ptr;
    j          = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (!w_rr_found && w_nonempty[IDW'(j)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = IDW'(j);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Grant selection. A held burst wins outright; otherwise a beat already
  // offered keeps its grant so the payload cannot change under backpressure.
  // With nothing to offer the grant rests on r_rr_ptr.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant = r_rr_ptr;
    if (r_locked) begin
      w_grant = r_lock_id;
    end else if (r_pend_valid) begin
      w_grant = r_pend_id;
    end else if (w_rr_found) begin
      w_grant = w_rr_idx;
    end
  end

  assign w_out_valid = w_nonempty[w_grant];
  assign w_xfer      = w_out_valid && out_ready;

  // Explicit wrap so non-power-of-two N never produces an index of N.
  assign w_next_ptr  = (w_grant == IDW'(N - 1)) ? '0 : (w_grant + IDW'(1));

  assign out_valid   = w_out_valid;
  assign out_data    = w_head[w_grant][WIDTH-1:0];
  assign out_last    = w_head[w_grant][WIDTH];
  assign out_id      = w_grant;
  assign locked      = r_locked;

  // --------------------------------------------------------------------------
  // Arbitration state update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_locked     <= 1'b0;
      r_lock_id    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_id    <= '0;
    end else if (w_xfer) begin
      r_pend_valid <= 1'b0;
      if (out_last) begin
        r_locked <= 1'b0;
        r_rr_ptr <= w_next_ptr;
      end else begin
        r_locked  <= 1'b1;
        r_lock_id <= w_grant;
      end
    end else if (!r_locked && w_out_valid) begin
      // Stalled offer while unlocked: pin the grant until it is taken.
      r_pend_valid <= 1'b1;
      r_pend_id    <= w_grant;
    end
  end

endmodule
`default_nettype wire
